// File: rtl/prbs7_checker.sv
// rtl/prbs7_checker.sv - PRBS7 (x^7+x^6+1) self-synchronizing checker
// Seeds, hunts for LOCK_CNT clean predictions, then counts bits and errors with windowed loss-of-lock.
module prbs7_checker #(
    parameter int LOCK_CNT   = 32,
    parameter int WIN        = 64,
    parameter int UNLOCK_ERR = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in,
    input  logic        en,
    input  logic        clr,
    output logic        lock,
    output logic        err,
    output logic [15:0] err_cnt,
    output logic [31:0] bit_cnt
);

    localparam int MW  = $clog2(LOCK_CNT + 1);
    localparam int WBW = $clog2(WIN + 1);
    localparam int WEW = $clog2(UNLOCK_ERR + 1);
    localparam logic [MW-1:0]  MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [WBW-1:0] WIN_LAST   = WBW'(WIN - 1);
    localparam logic [WEW-1:0] ERR_LAST   = WEW'(UNLOCK_ERR - 1);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [6:0]      r_sr;
    logic [6:0]      w_sr_nxt;
    logic [2:0]      r_seed;
    logic [2:0]      w_seed_nxt;
    logic [MW-1:0]   r_match;
    logic [MW-1:0]   w_match_nxt;
    logic [WBW-1:0]  r_wbit;
    logic [WBW-1:0]  w_wbit_nxt;
    logic [WEW-1:0]  r_werr;
    logic [WEW-1:0]  w_werr_nxt;
    logic            r_lock;
    logic            r_err;
    logic            w_err_nxt;
    logic [15:0]     r_err_cnt;
    logic [15:0]     w_err_cnt_nxt;
    logic [31:0]     r_bit_cnt;
    logic [31:0]     w_bit_cnt_nxt;
    logic            w_mis;

    assign w_mis = in ^ (r_sr[6] ^ r_sr[5]);

    always_comb begin
        w_state_nxt   = r_state;
        w_sr_nxt      = r_sr;
        w_seed_nxt    = r_seed;
        w_match_nxt   = r_match;
        w_wbit_nxt    = r_wbit;
        w_werr_nxt    = r_werr;
        w_err_nxt     = 1'b0;
        w_err_cnt_nxt = r_err_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        if (en) begin
            w_sr_nxt = {r_sr[5:0], in};
            case (r_state)
                SEED: begin
                    if (r_seed == 3'd6) begin
                        w_state_nxt = HUNT;
                        w_seed_nxt  = 3'd0;
                        w_match_nxt = '0;
                    end else begin
                        w_seed_nxt = r_seed + 3'd1;
                    end
                end
                HUNT: begin
                    // An all-zero history is the LFSR lock-up state, never a valid match.
                    if (!w_mis && (r_sr != 7'd0)) begin
                        if (r_match == MATCH_LAST) begin
                            w_state_nxt = LOCKED;
                            w_match_nxt = '0;
                            w_wbit_nxt  = '0;
                            w_werr_nxt  = '0;
                        end else begin
                            w_match_nxt = r_match + MW'(1);
                        end
                    end else begin
                        w_match_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (r_bit_cnt != 32'hFFFF_FFFF)
                        w_bit_cnt_nxt = r_bit_cnt + 32'd1;
                    if (w_mis && (r_err_cnt != 16'hFFFF))
                        w_err_cnt_nxt = r_err_cnt + 16'd1;
                    if (w_mis && (r_werr == ERR_LAST)) begin
                        w_state_nxt = SEED;
                        w_seed_nxt  = 3'd0;
                        w_wbit_nxt  = '0;
                        w_werr_nxt  = '0;
                    end else begin
                        w_err_nxt  = w_mis;
                        w_werr_nxt = w_mis ? r_werr + WEW'(1) : r_werr;
                        if (r_wbit == WIN_LAST) begin
                            w_wbit_nxt = '0;
                            w_werr_nxt = '0;
                        end else begin
                            w_wbit_nxt = r_wbit + WBW'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = SEED;
                    w_seed_nxt  = 3'd0;
                end
            endcase
        end
        if (clr) begin
            w_err_cnt_nxt = 16'd0;
            w_bit_cnt_nxt = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= SEED;
            r_sr      <= 7'd0;
            r_seed    <= 3'd0;
            r_match   <= '0;
            r_wbit    <= '0;
            r_werr    <= '0;
            r_lock    <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= 16'd0;
            r_bit_cnt <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_sr      <= w_sr_nxt;
            r_seed    <= w_seed_nxt;
            r_match   <= w_match_nxt;
            r_wbit    <= w_wbit_nxt;
            r_werr    <= w_werr_nxt;
            r_lock    <= (w_state_nxt == LOCKED);
            r_err     <= w_err_nxt;
            r_err_cnt <= w_err_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
        end
    end

    assign lock    = r_lock;
    assign err     = r_err;
    assign err_cnt = r_err_cnt;
    assign bit_cnt = r_bit_cnt;

endmodule

// File: tb/tb_prbs7_checker.sv
// tb/tb_prbs7_checker.sv - scoreboard bench for prbs7_checker
// Two instances: default parameters, and one that never unlocks so err_cnt can be driven to saturation.
module tb_prbs7_checker;

    localparam int B_LOCKC = 8;
    localparam int B_WIN   = 64;
    localparam int B_UERR  = 65;
    localparam int B_CLR   = 65800;
    localparam int B_END   = 65900;

    typedef struct packed {
        logic [1:0]  mode;
        logic [7:0]  seedc;
        logic [15:0] matchc;
        logic [15:0] wbit;
        logic [15:0] werr;
        logic [6:0]  hist;
        logic        lock;
        logic        err;
        logic [15:0] errc;
        logic [31:0] bitc;
    } mdl_t;

    typedef struct packed {
        logic        al;
        logic        ae;
        logic [15:0] aec;
        logic [31:0] abc;
        logic        bl;
        logic        be;
        logic [15:0] bec;
        logic [31:0] bbc;
    } exp_t;

    logic        clk = 1'b0;
    logic        a_rst = 1'b1, a_in = 1'b0, a_en = 1'b0, a_clr = 1'b0;
    logic        b_rst = 1'b1, b_in = 1'b0, b_en = 1'b0, b_clr = 1'b0;
    logic        a_lock, a_err, b_lock, b_err;
    logic [15:0] a_err_cnt, b_err_cnt;
    logic [31:0] a_bit_cnt, b_bit_cnt;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   shown  = 0;
    int   cyc    = 0;
    mdl_t ma = '0;
    mdl_t mb = '0;
    logic [6:0] ga = 7'h5A;
    logic [6:0] gb = 7'h3C;

    prbs7_checker u_a (
        .clk(clk), .rst(a_rst), .in(a_in), .en(a_en), .clr(a_clr),
        .lock(a_lock), .err(a_err), .err_cnt(a_err_cnt), .bit_cnt(a_bit_cnt)
    );

    prbs7_checker #(.LOCK_CNT(B_LOCKC), .WIN(B_WIN), .UNLOCK_ERR(B_UERR)) u_b (
        .clk(clk), .rst(b_rst), .in(b_in), .en(b_en), .clr(b_clr),
        .lock(b_lock), .err(b_err), .err_cnt(b_err_cnt), .bit_cnt(b_bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (shown < 100) begin
                shown++;
                $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
            end
        end
    endtask

    // Reference behaviour: history of received bits, predicted bit = bit 7 ago xor bit 6 ago.
    function automatic mdl_t mstep(mdl_t mi, logic i, logic e, logic c, logic r,
                                   int lc, int win, int ue);
        mdl_t m;
        logic mis;
        m = mi;
        if (r) return '0;
        m.err = 1'b0;
        if (e) begin
            mis = (i != (m.hist[6] ^ m.hist[5]));
            if (m.mode == 2'd0) begin
                m.seedc = m.seedc + 8'd1;
                if (int'(m.seedc) == 7) begin
                    m.mode = 2'd1; m.seedc = 8'd0; m.matchc = 16'd0;
                end
            end else if (m.mode == 2'd1) begin
                if (!mis && m.hist != 7'd0) begin
                    m.matchc = m.matchc + 16'd1;
                    if (int'(m.matchc) == lc) begin
                        m.mode = 2'd2; m.matchc = 16'd0; m.wbit = 16'd0; m.werr = 16'd0;
                    end
                end else begin
                    m.matchc = 16'd0;
                end
            end else begin
                if (m.bitc != 32'hFFFF_FFFF) m.bitc = m.bitc + 32'd1;
                if (mis) begin
                    if (m.errc != 16'hFFFF) m.errc = m.errc + 16'd1;
                    m.werr = m.werr + 16'd1;
                end
                if (int'(m.werr) == ue) begin
                    m.mode = 2'd0; m.seedc = 8'd0; m.wbit = 16'd0; m.werr = 16'd0;
                end else begin
                    m.err  = mis;
                    m.wbit = m.wbit + 16'd1;
                    if (int'(m.wbit) == win) begin
                        m.wbit = 16'd0; m.werr = 16'd0;
                    end
                end
            end
            m.hist = {m.hist[5:0], i};
        end
        if (c) begin
            m.errc = 16'd0;
            m.bitc = 32'd0;
        end
        m.lock = (m.mode == 2'd2);
        return m;
    endfunction

    function automatic logic gen_a();
        logic b;
        b  = ga[6] ^ ga[5];
        ga = {ga[5:0], b};
        return b;
    endfunction

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic tick(input logic ai, input logic ae, input logic ac, input logic ar);
        logic bi, br, bc;
        exp_t x;
        @(negedge clk);
        if (cyc == B_CLR) begin
            chk("b_err_cnt_saturated", {16'd0, b_err_cnt}, 32'h0000_FFFF);
            chk("b_lock_held", {31'd0, b_lock}, 32'd1);
        end
        if (cyc == B_CLR + 1)
            chk("b_err_cnt_after_clr", {16'd0, b_err_cnt}, 32'd0);
        br = (cyc < 2);
        bc = (cyc == B_CLR);
        if (cyc < 30) begin
            bi = gb[6] ^ gb[5];
            gb = {gb[5:0], bi};
        end else begin
            bi = 1'b1;
        end
        a_in = ai; a_en = ae; a_clr = ac; a_rst = ar;
        b_in = bi; b_en = 1'b1; b_clr = bc; b_rst = br;
        ma = mstep(ma, ai, ae, ac, ar, 32, 64, 4);
        mb = mstep(mb, bi, 1'b1, bc, br, B_LOCKC, B_WIN, B_UERR);
        x = '{al: ma.lock, ae: ma.err, aec: ma.errc, abc: ma.bitc,
              bl: mb.lock, be: mb.err, bec: mb.errc, bbc: mb.bitc};
        exp_q.push_back(x);
        if (ar) begin
            #1;
            chk("a_rst_lock_async", {31'd0, a_lock}, 32'd0);
            chk("a_rst_err_async", {31'd0, a_err}, 32'd0);
            chk("a_rst_err_cnt_async", {16'd0, a_err_cnt}, 32'd0);
            chk("a_rst_bit_cnt_async", a_bit_cnt, 32'd0);
        end
        cyc++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("a_lock", {31'd0, a_lock}, {31'd0, e.al});
                chk("a_err", {31'd0, a_err}, {31'd0, e.ae});
                chk("a_err_cnt", {16'd0, a_err_cnt}, {16'd0, e.aec});
                chk("a_bit_cnt", a_bit_cnt, e.abc);
                chk("b_lock", {31'd0, b_lock}, {31'd0, e.bl});
                chk("b_err", {31'd0, b_err}, {31'd0, e.be});
                chk("b_err_cnt", {16'd0, b_err_cnt}, {16'd0, e.bec});
                chk("b_bit_cnt", b_bit_cnt, e.bbc);
            end
        end
    end

    initial begin : stimulus
        logic e, b;
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b1);

        for (int i = 1; i <= 1000; i++) begin
            tick(gen_a(), 1'b1, 1'b0, 1'b0);
            if (i == 38 || i == 39) begin
                settle();
                chk("lock_edge_39", {31'd0, a_lock}, (i == 39) ? 32'd1 : 32'd0);
            end
            if (i == 1000) begin
                settle();
                chk("clean_bit_cnt_961", a_bit_cnt, 32'd961);
                chk("clean_err_cnt_0", {16'd0, a_err_cnt}, 32'd0);
            end
        end

        for (int i = 1; i <= 200; i++)
            tick(gen_a() ^ (i == 100), 1'b1, 1'b0, 1'b0);

        for (int i = 1; i <= 200; i++)
            tick(gen_a() ^ (i == 20 || i == 30 || i == 40 || i == 50), 1'b1, 1'b0, 1'b0);

        tick(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 200; i++) begin
            e = (i % 2 == 1);
            b = e ? gen_a() : 1'($urandom % 2);
            tick(b, e, 1'b0, 1'b0);
            if (i == 76 || i == 77) begin
                settle();
                chk("toggle_en_lock_77", {31'd0, a_lock}, (i == 77) ? 32'd1 : 32'd0);
            end
        end

        tick(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 300; i++)
            tick(1'b0, 1'b1, 1'b0, 1'b0);
        settle();
        chk("zeros_no_lock", {31'd0, a_lock}, 32'd0);
        chk("zeros_err_cnt", {16'd0, a_err_cnt}, 32'd0);
        chk("zeros_bit_cnt", a_bit_cnt, 32'd0);

        tick(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 4000; i++) begin
            e = ($urandom % 8) != 0;
            b = e ? (gen_a() ^ (($urandom % 40) == 0)) : 1'($urandom % 2);
            tick(b, e, e && (($urandom % 300) == 0), 1'b0);
        end

        tick(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 60; i++)
            tick(gen_a(), 1'b1, 1'b0, 1'b0);
        settle();
        chk("pre_rst_locked", {31'd0, a_lock}, 32'd1);
        tick(gen_a(), 1'b1, 1'b0, 1'b1);

        while (cyc < B_END) begin
            e = ($urandom % 4) != 0;
            b = e ? (gen_a() ^ (($urandom % 64) == 0)) : 1'($urandom % 2);
            tick(b, e, 1'b0, 1'b0);
        end
        settle();
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
